// File: rtl/scale_pkg.sv
// Shared types and constants for the power-of-two scale sequencer.
package scale_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_DIV = 1'b0;
    localparam logic MODE_MUL = 1'b1;

    // Rails of an n+1 bit signed value.
    function automatic int SAT_MAX(input int n);
        return (1 << n) - 1;
    endfunction

    function automatic int SAT_MIN(input int n);
        return -(1 << n);
    endfunction

endpackage

// File: rtl/scale_sequencer_if.sv
// Request / result handshake bundle between the operand path and the scale sequencer.
interface scale_sequencer_if #(
    parameter int N  = 4,
    parameter int CW = 3
);
    logic                in_valid;
    logic                in_ready;
    logic signed [N:0]   in_data;
    logic [CW-1:0]       in_count;
    logic                in_mul;
    logic                out_valid;
    logic                out_ready;
    logic signed [N:0]   out_data;
    logic                out_ovf;
    logic                busy;

    modport master (
        output in_valid, in_data, in_count, in_mul, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, busy
    );

    modport slave (
        input  in_valid, in_data, in_count, in_mul, out_ready,
        output in_ready, out_valid, out_data, out_ovf, busy
    );
endinterface

// File: rtl/scale_step.sv
// One combinational scaling step: x2 with saturation, or /2 truncating toward zero.
module scale_step
    import scale_pkg::*;
#(
    parameter int N = 4
) (
    input  logic signed [N:0] a,
    input  logic              mul,
    output logic signed [N:0] y,
    output logic              sat
);
    localparam logic signed [N+1:0] MAX_W = (N+2)'(SAT_MAX(N));
    localparam logic signed [N+1:0] MIN_W = (N+2)'(SAT_MIN(N));

    logic signed [N+1:0] prod;
    logic signed [N:0]   half;

    assign prod = {a, 1'b0};
    assign half = a >>> 1;

    always_comb begin
        // Floor shift rounds negative odd values down; nudge them back toward zero.
        y   = half + {{N{1'b0}}, a[N] & a[0]};
        sat = 1'b0;
        if (mul == MODE_MUL) begin
            if (prod > MAX_W) begin
                y   = MAX_W[N:0];
                sat = 1'b1;
            end else if (prod < MIN_W) begin
                y   = MIN_W[N:0];
                sat = 1'b1;
            end else begin
                y = prod[N:0];
            end
        end
    end
endmodule

// File: rtl/scale_sequencer.sv
// Iterative power-of-two scaler: one x2 or /2 step per clock, single transaction in flight.
module scale_sequencer
    import scale_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = 3
) (
    input  logic              clk,
    input  logic              reset,
    scale_sequencer_if.slave  bus
);
    state_t             state_reg, state_next;
    logic signed [N:0]  acc_reg, acc_next;
    logic [CW-1:0]      cnt_reg, cnt_next;
    logic               mode_reg, mode_next;
    logic               ovf_reg, ovf_next;
    logic signed [N:0]  step_y;
    logic               step_sat;

    scale_step #(.N(N)) u_step (
        .a   (acc_reg),
        .mul (mode_reg),
        .y   (step_y),
        .sat (step_sat)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            mode_reg  <= MODE_DIV;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            mode_reg  <= mode_next;
            ovf_reg   <= ovf_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        mode_next  = mode_reg;
        ovf_next   = ovf_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    acc_next   = bus.in_data;
                    cnt_next   = bus.in_count;
                    mode_next  = bus.in_mul;
                    ovf_next   = 1'b0;
                    state_next = (bus.in_count == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                acc_next = step_y;
                ovf_next = ovf_reg | step_sat;
                cnt_next = cnt_reg - CW'(1);
                if (cnt_reg == CW'(1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Result is only presented in DONE so the consumer never sees intermediate steps.
    assign bus.in_ready  = (state_reg == ST_IDLE) && !reset;
    assign bus.out_valid = (state_reg == ST_DONE);
    assign bus.out_data  = (state_reg == ST_DONE) ? acc_reg : '0;
    assign bus.out_ovf   = (state_reg == ST_DONE) ? ovf_reg : 1'b0;
    assign bus.busy      = (state_reg == ST_RUN) || (state_reg == ST_DONE);
endmodule

// File: tb/tb_scale_sequencer.sv
// Directed bench for scale_sequencer with hand-computed results (N=4, CW=3).
module tb_scale_sequencer;
    import scale_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    scale_sequencer_if #(.N(4), .CW(3)) bus ();

    scale_sequencer #(.N(4), .CW(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check_val(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one job with out_ready high and check latency, result, ovf and return to idle.
    task automatic run_job(input string tag, input int data, input logic mul, input int k,
                           input int exp_data, input logic exp_ovf);
        int lat;
        check_val({tag, "_ready"}, bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_data  = 5'(data);
        bus.in_count = 3'(k);
        bus.in_mul   = mul;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 5'sd10;
        bus.in_count = 3'd5;
        bus.in_mul   = ~mul;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val({tag, "_lat"}, lat, (k == 0) ? 1 : k + 1);
        check_val({tag, "_data"}, bus.out_data, exp_data);
        check_val({tag, "_ovf"}, bus.out_ovf, exp_ovf);
        $display("job %s: in=%0d mul=%0d k=%0d -> out=%0d ovf=%0d lat=%0d",
                 tag, data, mul, k, bus.out_data, bus.out_ovf, lat);
        @(posedge clk); #1;
        check_val({tag, "_done"}, bus.out_valid, 0);
    endtask

    initial begin
        int seen;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_count = '0;
        bus.in_mul   = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check_val("rst_valid", bus.out_valid, 0);
        check_val("rst_data", bus.out_data, 0);
        check_val("rst_ovf", bus.out_ovf, 0);
        check_val("rst_busy", bus.busy, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check_val("rst_ready", bus.in_ready, 1);
        $display("reset released: in_ready=%0d", bus.in_ready);

        run_job("mul_3_k2", 3, MODE_MUL, 2, 12, 1'b0);
        run_job("sat_pos", 5, MODE_MUL, 2, 15, 1'b1);
        run_job("sat_neg", -9, MODE_MUL, 1, -16, 1'b1);
        run_job("pass_k0", -6, MODE_MUL, 0, -6, 1'b0);
        run_job("div_m7", -7, MODE_DIV, 2, -1, 1'b0);
        run_job("div_m1", -1, MODE_DIV, 1, 0, 1'b0);
        run_job("div_15_k7", 15, MODE_DIV, 7, 0, 1'b0);

        // Backpressure with stray requests during RUN and DONE.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 5'sd1;
        bus.in_count  = 3'd3;
        bus.in_mul    = MODE_MUL;
        @(posedge clk); #1;
        bus.in_data  = 5'sd9;
        bus.in_count = 3'd0;
        bus.in_mul   = MODE_DIV;
        check_val("bp_run_ready", bus.in_ready, 0);
        seen = 0;
        while (!bus.out_valid && seen < 20) begin
            @(posedge clk); #1;
            seen++;
        end
        check_val("bp_reach_done", seen, 3);
        for (int i = 0; i < 5; i++) begin
            check_val("bp_valid", bus.out_valid, 1);
            check_val("bp_data", bus.out_data, 8);
            check_val("bp_ready", bus.in_ready, 0);
            @(posedge clk); #1;
        end
        $display("job bp_1_k3: out=%0d ovf=%0d held 5 cycles", bus.out_data, bus.out_ovf);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check_val("bp_release_valid", bus.out_valid, 0);
        check_val("bp_release_busy", bus.busy, 0);
        check_val("bp_release_ready", bus.in_ready, 1);

        // Abort a k=5 job in its second RUN cycle.
        bus.in_valid = 1'b1;
        bus.in_data  = 5'sd3;
        bus.in_count = 3'd5;
        bus.in_mul   = MODE_MUL;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check_val("abort_busy_before", bus.busy, 1);
        reset = 1'b1;
        #1;
        check_val("abort_valid", bus.out_valid, 0);
        check_val("abort_data", bus.out_data, 0);
        check_val("abort_ovf", bus.out_ovf, 0);
        check_val("abort_busy", bus.busy, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        check_val("abort_no_output", seen, 0);
        $display("job abort_k5: reset in RUN, outputs cleared");
        run_job("after_abort", 2, MODE_MUL, 1, 4, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
